// File: rtl/ifm_col_writer_pkg.sv
// Shared definitions for the ifmap column writer: FSM encoding, default
// widths and a constant-evaluable clog2 helper.
package ifm_col_writer_pkg;

  localparam int unsigned IFM_DATA_WIDTH = 8;
  localparam int unsigned IFM_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } ifm_state_e;

  // Ceiling log2, never less than 1 so a single-entry counter still has a bit.
  function automatic int unsigned ifm_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/ifm_col_writer_if.sv
// Stream-in / bank-write bundle of the ifmap column writer.
// master: upstream source and bank side; slave: the writer itself.
interface ifm_col_writer_if
  import ifm_col_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = IFM_ADDR_WIDTH,
  parameter int unsigned NUM_COL    = 4
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [NUM_COL-1:0]    write_req;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  write_req,
    input  write_addr,
    input  write_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output write_req,
    output write_addr,
    output write_data
  );

endinterface

// File: rtl/ifm_wr_addr_gen.sv
// Column-major address walker: addr_cnt runs 0..LEN-1, then col_cnt
// advances; both wrap back to 0 after the last column.
module ifm_wr_addr_gen
  import ifm_col_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IFM_ADDR_WIDTH,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_W      = ifm_clog2(NUM_COL),
  parameter int unsigned LEN        = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  clear,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr_cnt,
  output logic [COL_W-1:0]      col_cnt,
  output logic                  wrap_c,
  output logic                  last_c
);

  logic col_last_c;

  // End-of-column and end-of-block flags for the current position
  always_comb begin
    wrap_c     = (addr_cnt == ADDR_WIDTH'(LEN - 1));
    col_last_c = (col_cnt == COL_W'(NUM_COL - 1));
    last_c     = wrap_c & col_last_c;
  end

  // Counter pair; frozen whenever the clock enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      col_cnt  <= '0;
    end else if (clk_en) begin
      if (clear) begin
        addr_cnt <= '0;
        col_cnt  <= '0;
      end else if (step) begin
        if (wrap_c) begin
          addr_cnt <= '0;
          col_cnt  <= col_last_c ? '0 : col_cnt + COL_W'(1);
        end else begin
          addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ifm_col_writer.sv
// Ifmap column writer: accepts a streamed block and scatters it column-major
// into NUM_COL bank write ports with one cycle of write latency.
// Optional build macro IFM_WR_ZERO_PAD_EN appends PAD_LEN zero words to every
// column after the block, before done is raised.
module ifm_col_writer
  import ifm_col_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = IFM_ADDR_WIDTH,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_LEN    = 36
`ifdef IFM_WR_ZERO_PAD_EN
  ,
  parameter int unsigned PAD_LEN    = 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  ifm_col_writer_if.slave  bus,
  output logic             busy,
  output logic             done
);

  localparam int unsigned COL_W = ifm_clog2(NUM_COL);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
`ifdef IFM_WR_ZERO_PAD_EN
  localparam logic [1:0] PAD  = ST_PAD;
`endif
  localparam logic [1:0] DONE = ST_DONE;

  localparam logic [NUM_COL-1:0] REQ_ONE = NUM_COL'(1);

  logic [1:0]            state_q, state_d;
  logic [NUM_COL-1:0]    wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept_c;
  logic                  load_clr_c;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [COL_W-1:0]      col_cnt;
  logic                  blk_wrap_unused;
  logic                  blk_last_c;

  // Handshake: ready only while loading and the clock is enabled
  always_comb begin
    bus.in_ready = (state_q == LOAD) & clk_en;
    accept_c     = bus.in_ready & bus.in_valid;
    load_clr_c   = (state_q == IDLE) & start & clk_en;
  end

  ifm_wr_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COL    (NUM_COL),
    .COL_W      (COL_W),
    .LEN        (COL_LEN)
  ) u_blk_addr (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .clear    (load_clr_c),
    .step     (accept_c),
    .addr_cnt (addr_cnt),
    .col_cnt  (col_cnt),
    .wrap_c   (blk_wrap_unused),
    .last_c   (blk_last_c)
  );

`ifdef IFM_WR_ZERO_PAD_EN
  logic                  pad_step_c;
  logic [ADDR_WIDTH-1:0] pad_addr;
  logic [COL_W-1:0]      pad_col;
  logic                  pad_wrap_unused;
  logic                  pad_last_c;

  // Pad walker advances once per enabled cycle spent in PAD
  always_comb begin
    pad_step_c = (state_q == PAD) & clk_en;
  end

  ifm_wr_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COL    (NUM_COL),
    .COL_W      (COL_W),
    .LEN        (PAD_LEN)
  ) u_pad_addr (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .clear    (load_clr_c),
    .step     (pad_step_c),
    .addr_cnt (pad_addr),
    .col_cnt  (pad_col),
    .wrap_c   (pad_wrap_unused),
    .last_c   (pad_last_c)
  );
`endif

  // Next state and next values of the registered write port / status
  always_comb begin
    state_d   = state_q;
    wr_req_d  = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (accept_c) begin
          wr_req_d  = REQ_ONE << col_cnt;
          wr_addr_d = addr_cnt;
          wr_data_d = bus.in_data;
`ifdef IFM_WR_ZERO_PAD_EN
          if (blk_last_c) state_d = PAD;
`else
          done_d = blk_last_c;
          if (blk_last_c) state_d = DONE;
`endif
        end
      end
`ifdef IFM_WR_ZERO_PAD_EN
      PAD: begin
        wr_req_d  = REQ_ONE << pad_col;
        wr_addr_d = ADDR_WIDTH'(COL_LEN) + pad_addr;
        wr_data_d = '0;
        done_d    = pad_last_c;
        if (pad_last_c) state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Registered write port and status; updates only on enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_req_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clk_en) begin
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Strobe is masked by the enable so a frozen clock cannot repeat a write
  always_comb begin
    bus.write_req  = wr_req_q & {NUM_COL{clk_en}};
    bus.write_addr = wr_addr_q;
    bus.write_data = wr_data_q;
    busy           = busy_q;
    done           = done_q;
  end

endmodule

// File: tb/tb_ifm_col_writer.sv
// Scoreboard bench for ifm_col_writer (NUM_COL=4, COL_LEN=36).
// Build with +define+IFM_WR_ZERO_PAD_EN to exercise the zero-pad tail.
module tb_ifm_col_writer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned NC = 4;
  localparam int unsigned CL = 36;
  localparam int          NWORDS = NC * CL;
`ifdef IFM_WR_ZERO_PAD_EN
  localparam int unsigned PL = 2;
  localparam bit          PAD_MODE = 1'b1;
  localparam int          TOTAL = NC * CL + NC * PL;
`else
  localparam bit          PAD_MODE = 1'b0;
  localparam int          TOTAL = NC * CL;
`endif

  typedef struct packed {
    logic [NC-1:0] req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic clk;
  logic rst;
  logic clk_en;
  logic start;
  logic busy;
  logic done;

  ifm_col_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COL(NC)) bus ();

  ifm_col_writer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_COL    (NC),
    .COL_LEN    (CL)
`ifdef IFM_WR_ZERO_PAD_EN
    ,
    .PAD_LEN    (PL)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   wr_count;
  int   bank2_a5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected write(s) for accepted word k (plus pad tail after the last word)
  task automatic push_word(input int k);
    exp_t e;
    e.req  = NC'(1) << (k / CL);
    e.addr = AW'(k % CL);
    e.data = DW'(k);
    e.done = (k == NWORDS - 1) && !PAD_MODE;
    exp_q.push_back(e);
`ifdef IFM_WR_ZERO_PAD_EN
    if (k == NWORDS - 1) begin
      for (int c = 0; c < NC; c++) begin
        for (int p = 0; p < PL; p++) begin
          e.req  = NC'(1) << c;
          e.addr = AW'(CL + p);
          e.data = '0;
          e.done = (c == NC - 1) && (p == PL - 1);
          exp_q.push_back(e);
        end
      end
    end
`endif
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every visible write strobe
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.write_req != '0) begin
          checks++;
          wr_count++;
          if (bus.write_req == NC'(4) && bus.write_addr == AW'(5))
            bank2_a5 = int'(bus.write_data);
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: req=%b addr=%0d data=%0d", bus.write_req,
                     bus.write_addr, bus.write_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.write_req !== e.req || bus.write_addr !== e.addr ||
                bus.write_data !== e.data || done !== e.done) begin
              errors++;
              $display("FAIL write: got req=%b addr=%0d data=%0d done=%b expected req=%b addr=%0d data=%0d done=%b",
                       bus.write_req, bus.write_addr, bus.write_data, done,
                       e.req, e.addr, e.data, e.done);
            end
          end
`ifdef IFM_WR_ZERO_PAD_EN
          if (bus.write_addr >= AW'(CL)) check_val("in_ready_in_pad", int'(bus.in_ready), 0);
`endif
        end else begin
          check_val("done_without_write", int'(done), 0);
        end
      end
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_write_req", int'(bus.write_req), 0);
    check_val("rst_write_addr", int'(bus.write_addr), 0);
    check_val("rst_write_data", int'(bus.write_data), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_in_ready", int'(bus.in_ready), 0);
  endtask

  // Stream one block; optional bubbles, enable gap, stray start, or reset abort
  task automatic run_block(input int duty, input int gap_at, input int start_at,
                           input int abort_at);
    int k;
    int cyc;
    int gap_cnt;
    bit acc;
    wr_count = 0;
    bank2_a5 = -1;
    k = 0;
    cyc = 0;
    gap_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (k < NWORDS && cyc < 3000) begin
      bus.in_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      bus.in_data  = DW'(k);
      start        = (k == start_at);
      if (k == gap_at && gap_cnt < 3) begin
        clk_en = 1'b0;
        gap_cnt++;
      end else begin
        clk_en = 1'b1;
      end
      @(negedge clk);
      if (!clk_en) begin
        check_val("gap_in_ready", int'(bus.in_ready), 0);
        check_val("gap_write_req", int'(bus.write_req), 0);
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) push_word(k);
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        bus.in_valid = 1'b0;
        start  = 1'b0;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL block_timeout: accepted %0d of %0d words", k, NWORDS);
    end
  endtask

  // After the last word: done pulse, busy drop one cycle later, totals
  task automatic finish_block();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check_val("done_seen", int'(found), 1);
    check_val("busy_at_done", int'(busy), 1);
    @(negedge clk);
    check_val("busy_after_done", int'(busy), 0);
    check_val("in_ready_idle", int'(bus.in_ready), 0);
    check_val("write_count", wr_count, TOTAL);
    check_val("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_count = 0;
    bank2_a5 = -1;
    rst = 1'b1;
    clk_en = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Continuous stream
    run_block(100, -1, -1, -1);
    finish_block();
    check_val("bank2_addr5_data", bank2_a5, 77);

    // Bubbly source
    run_block(50, -1, -1, -1);
    finish_block();
    check_val("bubbly_bank2_addr5", bank2_a5, 77);

    // Clock-enable gap mid-load
    run_block(100, 60, -1, -1);
    finish_block();

    // Reset after word 50, then a clean reload
    run_block(100, -1, -1, 51);
    @(posedge clk);
    #1;
    run_block(100, -1, -1, -1);
    finish_block();

    // Stray start during LOAD
    run_block(100, -1, 20, -1);
    finish_block();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
